// File: rtl/uart_rx_byte_receiver.sv
// Oversampling 8N1 UART receiver feeding a small byte FIFO with a valid/ready port.
// Reports framing errors (one pulse per bad frame) and a sticky FIFO overrun flag.
module uart_rx_byte_receiver #(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int BAUD        = 115_200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       uart_rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  input  logic       overrun_clr_i,
  output logic       busy_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int PW           = AW + 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_e;

  logic             sync1_q;
  logic             sync2_q;
  logic             rx_s;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             frame_err_q;
  logic             busy_q;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic             overrun_q;

  logic             push_s;
  logic             pop_s;
  logic             empty_s;
  logic             full_s;
  logic             wr_en_s;
  logic             ovr_set_s;

  assign rx_s = sync2_q;

  // Two-flop synchronizer for the asynchronous line, parked at the idle level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= uart_rx_i;
      sync2_q <= sync1_q;
    end
  end

  // Receive FSM: start-bit qualification at mid-bit, then one sample per bit period.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (!rx_s) begin
            state_q <= ST_START;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            if (rx_s) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_DATA;
              busy_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              state_q <= ST_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ST_WAIT_IDLE;
              busy_q      <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_IDLE: begin
          // A break holds us here so it produces a single error pulse.
          if (rx_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_WAIT_IDLE;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // FIFO handshake decode; a pop frees the slot a same-cycle push lands in.
  always_comb begin
    push_s    = 1'b0;
    empty_s   = (wr_ptr_q == rd_ptr_q);
    full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    if ((state_q == ST_STOP) && (cnt_q == BIT_LAST) && rx_s) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    pop_s     = !empty_s && rx_ready_i;
    wr_en_s   = push_s && (!full_s || pop_s);
    ovr_set_s = push_s && full_s && !pop_s;
  end

  // Byte storage, pointers and the sticky overrun flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
        wr_ptr_q                <= wr_ptr_q + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (ovr_set_s) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr_i) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign rx_data_o   = mem_q[rd_ptr_q[AW-1:0]];
  assign rx_valid_o  = !empty_s;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx_byte_receiver.sv
// Randomized bench for uart_rx_byte_receiver: serial frames are driven onto the line and
// outputs are compared every cycle against a queue-based model of the receive FIFO.
module tb_uart_rx_byte_receiver;

  localparam int CPB   = 10;
  localparam int DEPTH = 4;
  // Line fall to stop-bit sample: 2 sync flops + 1 idle detect, half a bit, nine whole bits.
  localparam int PUSH_OFS = 3 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       uart_rx_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       overrun_clr_i;
  logic       busy_o;

  uart_rx_byte_receiver #(
    .CLK_FREQ_HZ(1_000_000),
    .BAUD       (100_000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .uart_rx_i    (uart_rx_i),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .overrun_clr_i(overrun_clr_i),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at_cyc;
    logic [7:0] data;
    bit         ok;
  } ev_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic [7:0] mq[$];
  ev_t        sched[$];
  bit         m_ovr = 1'b0;
  bit         m_fe = 1'b0;
  bit         mon_en = 1'b0;
  bit         rnd_done = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: frame outcomes land at their predicted edge; FIFO kept as a queue.
  initial begin
    bit  pop;
    bit  set_ovr;
    ev_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_i) begin
        mq.delete();
        sched.delete();
        m_ovr = 1'b0;
        m_fe  = 1'b0;
      end else begin
        pop     = (mq.size() != 0) && rx_ready_i;
        set_ovr = 1'b0;
        m_fe    = 1'b0;
        if (pop) void'(mq.pop_front());
        if (sched.size() != 0 && sched[0].at_cyc == cyc) begin
          e = sched.pop_front();
          if (!e.ok) m_fe = 1'b1;
          else if (mq.size() < DEPTH) mq.push_back(e.data);
          else set_ovr = 1'b1;
        end
        if (set_ovr) m_ovr = 1'b1;
        else if (overrun_clr_i) m_ovr = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check_val("valid", rx_valid_o, (mq.size() != 0));
        if (mq.size() != 0) check_val("data", rx_data_o, mq[0]);
        check_val("overrun", overrun_o, m_ovr);
        check_val("frame_err", frame_err_o, m_fe);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int hold_low);
    logic [9:0] fr;
    ev_t        e;
    fr = {stop_ok, b, 1'b0};
    @(posedge clk);
    #1;
    e.at_cyc = cyc + PUSH_OFS;
    e.data   = b;
    e.ok     = stop_ok;
    sched.push_back(e);
    for (int i = 0; i < 10; i++) begin
      uart_rx_i = fr[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    if (hold_low > 0) begin
      repeat (hold_low) @(posedge clk);
      #1;
    end
    uart_rx_i = 1'b1;
  endtask

  task automatic drain_check(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp_b [4];
    exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2; exp_b[3] = e3;
    rx_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("%s_valid%0d", tag, k), rx_valid_o, 1'b1);
      check_val($sformatf("%s_pop%0d", tag, k), rx_data_o, exp_b[k]);
      @(posedge clk);
      #1;
    end
    check_val($sformatf("%s_empty", tag), rx_valid_o, 1'b0);
    rx_ready_i = 1'b0;
  endtask

  initial begin
    int         nv;
    logic [7:0] cap;
    bit         seen_idle;
    logic [9:0] fr;

    rst_i = 1'b1; uart_rx_i = 1'b1; rx_ready_i = 1'b0; overrun_clr_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_i  = 1'b0;
    mon_en = 1'b1;
    check_val("rst_data", rx_data_o, 8'h00);
    check_val("rst_valid", rx_valid_o, 1'b0);
    check_val("rst_ferr", frame_err_o, 1'b0);
    check_val("rst_ovr", overrun_o, 1'b0);
    check_val("rst_busy", busy_o, 1'b0);

    // 1: single byte with consumer ready.
    rx_ready_i = 1'b1;
    nv = 0; cap = 8'h00;
    fork
      send_byte(8'hA5, 1'b1, 0);
      begin
        repeat (110) begin
          @(negedge clk);
          if (rx_valid_o) begin nv++; cap = rx_data_o; end
        end
      end
    join
    check_val("t1_valid_cycles", nv, 1);
    check_val("t1_byte", cap, 8'hA5);
    rx_ready_i = 1'b0;

    // 2: short glitch is rejected.
    repeat (5) @(posedge clk);
    #1;
    uart_rx_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("t2_busy_glitch", busy_o, 1'b1);
    uart_rx_i = 1'b1;
    seen_idle = 1'b0;
    for (int k = 0; k < 6 && !seen_idle; k++) begin
      @(posedge clk);
      #1;
      if (!busy_o) seen_idle = 1'b1;
    end
    check_val("t2_busy_release", seen_idle, 1'b1);

    // 3: bad stop bit followed by a held-low line.
    repeat (5) @(posedge clk);
    fork
      send_byte(8'h3C, 1'b0, 40);
      begin
        @(posedge clk);
        #1;
        repeat (138) @(posedge clk);
        #1;
        check_val("t3_busy_break", busy_o, 1'b1);
      end
    join
    repeat (4) @(posedge clk);
    #1;
    check_val("t3_busy_after", busy_o, 1'b0);

    // 4: overrun with consumer stalled, then in-order drain and clear.
    for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b1, 0);
    check_val("t4_ovr_set", overrun_o, 1'b1);
    drain_check("t4", 8'h01, 8'h02, 8'h03, 8'h04);
    overrun_clr_i = 1'b1;
    @(posedge clk);
    #1;
    overrun_clr_i = 1'b0;
    check_val("t4_ovr_clr", overrun_o, 1'b0);

    // 5: push into a full FIFO on the very edge a pop happens.
    send_byte(8'h11, 1'b1, 0);
    send_byte(8'h22, 1'b1, 0);
    send_byte(8'h33, 1'b1, 0);
    send_byte(8'h44, 1'b1, 0);
    fork
      send_byte(8'h77, 1'b1, 0);
      begin
        @(posedge clk);
        #1;
        repeat (PUSH_OFS - 1) @(posedge clk);
        #1;
        rx_ready_i = 1'b1;
        @(posedge clk);
        #1;
        rx_ready_i = 1'b0;
      end
    join
    check_val("t5_no_ovr", overrun_o, 1'b0);
    drain_check("t5", 8'h22, 8'h33, 8'h44, 8'h77);

    // 6: reset during data bit 4 with a full FIFO and overrun set.
    for (int b = 0; b < 5; b++) send_byte(8'h80 + 8'(b), 1'b1, 0);
    check_val("t6_pre_ovr", overrun_o, 1'b1);
    fr = {1'b1, 8'h5A, 1'b0};
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      uart_rx_i = fr[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    uart_rx_i = fr[4];
    repeat (5) @(posedge clk);
    #1;
    rst_i = 1'b1;
    uart_rx_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    check_val("t6_data", rx_data_o, 8'h00);
    check_val("t6_valid", rx_valid_o, 1'b0);
    check_val("t6_ferr", frame_err_o, 1'b0);
    check_val("t6_ovr", overrun_o, 1'b0);
    check_val("t6_busy", busy_o, 1'b0);
    repeat (5) @(posedge clk);
    send_byte(8'hC3, 1'b1, 0);
    check_val("t6_c3_valid", rx_valid_o, 1'b1);
    check_val("t6_c3_data", rx_data_o, 8'hC3);
    rx_ready_i = 1'b1;
    @(posedge clk);
    #1;
    rx_ready_i = 1'b0;

    // Random frames, random consumer stalls, occasional bad stop bits and overrun clears.
    fork
      begin
        for (int f = 0; f < 20; f++) begin
          bit ok;
          ok = ($urandom_range(0, 5) != 0);
          send_byte(8'($urandom()), ok, 0);
          repeat ($urandom_range(1, 4)) @(posedge clk);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          rx_ready_i    = ($urandom_range(0, 2) == 0);
          overrun_clr_i = ($urandom_range(0, 15) == 0);
        end
      end
    join
    rx_ready_i    = 1'b1;
    overrun_clr_i = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_val("final_empty", rx_valid_o, 1'b0);
    rx_ready_i = 1'b0;

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
